cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
- Control-unit sequencer; sits directly upstream of the per-class instruction-word decoders (MOVZ, ALU-immediate, load/store, branch).
- Owns the instruction register and the execution-step state. Feeds I and state to the decoders.
- Consumes the 33-bit control word returned by the selected decoder and drives the final, masked control word to the datapath.
- Sequences fetch, multi-step execute and halt.

Parameters:
- FETCH_TIMEOUT, 16, number of cycles imem_ready may stay low in FETCH before a fault is raised.
- MAX_STEPS, 4, maximum execute steps per instruction; must be ≤ 4 because the next_state field is 2 bits.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction fetch request; address is the current PC, supplied by the datapath.
- imem_ready  input  1  instruction data valid this cycle.
- imem_data  input  32  fetched instruction word.
- I  output  32  instruction register contents, to the decoders.
- state  output  2  current execute step, to the decoders.
- cw_in  input  33  control word from the selected decoder.
- cw_out  output  33  control word to the datapath.
- halt_req  input  1  request to stop after the current instruction.
- halted  output  1  FSM is in HALT.
- fault  output  1  sticky error flag.
- retired  output  32  count of completed instructions.

Behaviour:
- Control-word bit map, for both cw_in and cw_out:
  - [32] alu_en, [31] alu_bs, [30:26] alu_fs, [25] rf_b_en
  - [24:20] rf_sa, [19:15] rf_sb, [14:10] rf_da
  - [9] rf_w, [8] ram_en, [7] ram_w
  - [6] pc_en, [5:4] pc_fs, [3] pc_is, [2] status_ld, [1:0] next_state
- NOP word: every bit 0 except rf_sa = rf_sb = rf_da = 5'd31.
- FSM states: FETCH, EXEC, HALT.
- Reset, synchronous and active-high:
  - FSM=FETCH, I=32'h0, step=0, timeout counter=0, retired=0, fault=0.
  - Reset overrides any in-flight fetch or execute step; no partial register write may follow.
- FETCH:
  - imem_req=1, cw_out=NOP, state=2'b00.
  - On imem_ready=1: I<=imem_data, step<=0, FSM->EXEC next cycle. Fetch latency is one cycle minimum.
  - Each cycle with imem_ready=0 increments the timeout counter.
  - When the counter reaches FETCH_TIMEOUT: fault<=1, FSM->HALT.
- EXEC:
  - imem_req=0, state=step, cw_out=cw_in with masking.
  - If cw_in.next_state != 0 (non-final step):
    - cw_out pc_en, pc_fs and status_ld are forced to 0, so the PC advances exactly once per instruction.
    - step<=cw_in.next_state and the FSM stays in EXEC.
    - If this would be the MAX_STEPS-th consecutive EXEC cycle of the instruction: fault<=1, FSM->HALT, and cw_out rf_w/ram_w are forced to 0 this cycle.
  - If cw_in.next_state == 0 (final step):
    - cw_out = cw_in unmasked.
    - retired<=retired+1, wrapping modulo 2^32.
    - FSM->HALT if halt_req=1 this cycle, else FSM->FETCH.
- HALT:
  - cw_out=NOP, imem_req=0, halted=1.
  - Leaves only on reset.
- halt_req:
  - Sampled only on the final EXEC step.
  - When asserted during FETCH it is ignored; the requester must hold it until halted=1.
- fault stays 1 until reset.
- A decoder must return next_state=0 for a single-step instruction; the MOVZ decoder does.

Test Plan:
- MOVZ single step: reset, then imem_data=32'hD2800541 with imem_ready=1 in cycle 1 → I=32'hD2800541 in cycle 2; with cw_in next_state=0, cw_out equals cw_in; retired becomes 1; FSM returns to FETCH in cycle 3.
- Two-step instruction: cw_in with next_state=2'b01, pc_fs=2'b01, status_ld=1 → cw_out pc_fs=0, pc_en=0, status_ld=0 and state=1 the next cycle; with next_state=0 on that step, pc_fs=2'b01 passes through and retired increments once.
- Fetch timeout: hold imem_ready=0 for 16 cycles → fault=1 and halted=1 on cycle 17; cw_out=NOP thereafter.
- Step overrun: cw_in next_state stuck at 2'b01 → fault=1 after the 4th EXEC cycle; rf_w=0 on that cycle; FSM in HALT.
- halt_req asserted on a final step → halted=1 next cycle, imem_req stays 0; asserting reset for one cycle restores FETCH with retired=0.
- Reset mid-EXEC at step 1 → next cycle FSM=FETCH, cw_out=NOP, I=0, fault=0.

Source files
------------

// File: rtl/cu_sequencer_if.sv
// Sequencer-facing bus: instruction fetch handshake, decoder feedback and status.
// The master side is the sequencer; the slave side is memory, decoders and datapath.
interface cu_sequencer_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] I;
    logic [1:0]  state;
    logic [32:0] cw_in;
    logic [32:0] cw_out;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    modport master (
        output imem_req, I, state, cw_out, halted, fault, retired,
        input  imem_ready, imem_data, cw_in, halt_req
    );

    modport slave (
        input  imem_req, I, state, cw_out, halted, fault, retired,
        output imem_ready, imem_data, cw_in, halt_req
    );
endinterface

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: owns the instruction register and execute step, sequences
// fetch / multi-step execute / halt, and masks the decoder control word for the datapath.
module cu_sequencer #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int MAX_STEPS     = 4    // at most 4: next_state is a 2-bit field
) (
    input  logic            clock,
    input  logic            reset,
    cu_sequencer_if.master  bus
);
    localparam int             TW        = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(FETCH_TIMEOUT - 1);
    localparam logic [1:0]     STEP_LAST = 2'(MAX_STEPS - 1);
    localparam logic [32:0]    NOP_WORD  = 33'h0_01FF_FC00;

    // Bit positions within the control word.
    localparam int PC_EN     = 6;
    localparam int PC_FS_HI  = 5;
    localparam int PC_FS_LO  = 4;
    localparam int STATUS_LD = 2;
    localparam int RF_W      = 9;
    localparam int RAM_W     = 7;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fsm_t;

    fsm_t          fsm_reg;
    logic [31:0]   ir_reg;
    logic [1:0]    step_reg;
    logic [TW-1:0] timeout_reg;
    logic [1:0]    exec_cnt_reg;
    logic          fault_reg;
    logic [31:0]   retired_reg;
    logic          req_reg;
    logic          halted_reg;

    logic          final_step;
    logic          overrun;
    logic [32:0]   cw_next;

    assign final_step = (bus.cw_in[1:0] == 2'b00);
    assign overrun    = !final_step && (exec_cnt_reg == STEP_LAST);

    // Non-final steps never touch the PC or flags; an overrunning step also loses its writes.
    always_comb begin
        cw_next = NOP_WORD;
        if (fsm_reg == EXEC) begin
            cw_next = bus.cw_in;
            if (!final_step) begin
                cw_next[PC_EN]              = 1'b0;
                cw_next[PC_FS_HI:PC_FS_LO]  = 2'b00;
                cw_next[STATUS_LD]          = 1'b0;
            end
            if (overrun) begin
                cw_next[RF_W]  = 1'b0;
                cw_next[RAM_W] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_reg      <= FETCH;
            ir_reg       <= 32'h0;
            step_reg     <= 2'd0;
            timeout_reg  <= '0;
            exec_cnt_reg <= 2'd0;
            retired_reg  <= 32'h0;
            fault_reg    <= 1'b0;
            req_reg      <= 1'b1;
            halted_reg   <= 1'b0;
        end else begin
            case (fsm_reg)
                FETCH: begin
                    if (bus.imem_ready) begin
                        ir_reg       <= bus.imem_data;
                        step_reg     <= 2'd0;
                        exec_cnt_reg <= 2'd0;
                        timeout_reg  <= '0;
                        fsm_reg      <= EXEC;
                        req_reg      <= 1'b0;
                    end else if (timeout_reg == TO_LAST) begin
                        timeout_reg  <= timeout_reg + 1'b1;
                        fault_reg    <= 1'b1;
                        fsm_reg      <= HALT;
                        req_reg      <= 1'b0;
                        halted_reg   <= 1'b1;
                    end else begin
                        timeout_reg  <= timeout_reg + 1'b1;
                    end
                end
                EXEC: begin
                    if (final_step) begin
                        retired_reg <= retired_reg + 32'd1;
                        step_reg    <= 2'd0;
                        if (bus.halt_req) begin
                            fsm_reg    <= HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            fsm_reg    <= FETCH;
                            req_reg    <= 1'b1;
                        end
                    end else if (overrun) begin
                        fault_reg  <= 1'b1;
                        step_reg   <= 2'd0;
                        fsm_reg    <= HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        step_reg     <= bus.cw_in[1:0];
                        exec_cnt_reg <= exec_cnt_reg + 2'd1;
                    end
                end
                HALT: begin
                    fsm_reg <= HALT;
                end
                default: begin
                    fsm_reg    <= FETCH;
                    step_reg   <= 2'd0;
                    req_reg    <= 1'b1;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req = req_reg;
    assign bus.I        = ir_reg;
    assign bus.state    = step_reg;
    assign bus.cw_out   = cw_next;
    assign bus.halted   = halted_reg;
    assign bus.fault    = fault_reg;
    assign bus.retired  = retired_reg;
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed-plus-random bench for cu_sequencer; expectations come from an
// instruction-level model of fetch / execute / halt kept in this file.
module tb_cu_sequencer;
    localparam int          TIMEOUT  = 16;
    localparam int          MAXSTEPS = 4;
    localparam logic [32:0] NOP      = 33'h0_01FF_FC00;

    logic clock = 1'b0;
    logic reset = 1'b1;

    cu_sequencer_if bus();

    cu_sequencer #(.FETCH_TIMEOUT(TIMEOUT), .MAX_STEPS(MAXSTEPS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_I;
    logic [31:0] m_retired;
    logic        m_fault;
    logic        m_halted;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [32:0] rand_cw();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[32:0];
    endfunction

    task automatic check_status(input string tag);
        chk({tag, ".I"}, 33'(bus.I), 33'(m_I));
        chk({tag, ".retired"}, 33'(bus.retired), 33'(m_retired));
        chk({tag, ".fault"}, 33'(bus.fault), 33'(m_fault));
        chk({tag, ".halted"}, 33'(bus.halted), 33'(m_halted));
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.halt_req   = 1'b0;
        bus.imem_ready = 1'b0;
        bus.cw_in      = rand_cw();
        step_clk();
        reset = 1'b0;
        m_I = 32'h0; m_retired = 32'h0; m_fault = 1'b0; m_halted = 1'b0;
        #1;
        check_status("reset");
        chk("reset.imem_req", 33'(bus.imem_req), 33'd1);
        chk("reset.cw_out", bus.cw_out, NOP);
        chk("reset.state", 33'(bus.state), 33'd0);
    endtask

    // Wait 'delay' cycles with no data, then present the word for one cycle.
    task automatic fetch(input int delay, input logic [31:0] word);
        for (int i = 0; i < delay; i++) begin
            bus.imem_ready = 1'b0;
            bus.imem_data  = $urandom();
            #1;
            chk("fetch_wait.imem_req", 33'(bus.imem_req), 33'd1);
            chk("fetch_wait.cw_out", bus.cw_out, NOP);
            step_clk();
        end
        bus.imem_ready = 1'b1;
        bus.imem_data  = word;
        bus.cw_in      = rand_cw();
        #1;
        chk("fetch.imem_req", 33'(bus.imem_req), 33'd1);
        chk("fetch.cw_out", bus.cw_out, NOP);
        chk("fetch.state", 33'(bus.state), 33'd0);
        step_clk();
        bus.imem_ready = 1'b0;
        m_I = word;
        chk("fetch.I", 33'(bus.I), 33'(m_I));
    endtask

    // One execute cycle: idx is how many execute cycles this instruction already used.
    task automatic exec(input logic [32:0] cw, input logic hreq,
                        input logic [1:0] exp_state, input int idx);
        logic [32:0] exp_cw;
        logic        last;
        logic        over;
        bus.cw_in    = cw;
        bus.halt_req = hreq;
        last = (cw[1:0] == 2'b00);
        over = !last && (idx == MAXSTEPS - 1);
        exp_cw = cw;
        if (!last) begin
            exp_cw[6]   = 1'b0;   // pc_en
            exp_cw[5:4] = 2'b00;  // pc_fs
            exp_cw[2]   = 1'b0;   // status_ld
        end
        if (over) begin
            exp_cw[9] = 1'b0;     // rf_w
            exp_cw[7] = 1'b0;     // ram_w
        end
        #1;
        chk("exec.cw_out", bus.cw_out, exp_cw);
        chk("exec.state", 33'(bus.state), 33'(exp_state));
        chk("exec.imem_req", 33'(bus.imem_req), 33'd0);
        check_status("exec");
        step_clk();
        if (last) begin
            m_retired = m_retired + 32'd1;
            m_halted  = hreq;
        end else if (over) begin
            m_fault  = 1'b1;
            m_halted = 1'b1;
        end
        bus.halt_req = 1'b0;
        $display("exec idx=%0d cw=%h ns=%0d halt_req=%0b -> retired=%0d fault=%0b halted=%0b",
                 idx, cw, cw[1:0], hreq, bus.retired, bus.fault, bus.halted);
        check_status("post_exec");
        chk("post_exec.imem_req", 33'(bus.imem_req), 33'(last && !hreq));
    endtask

    task automatic run_instr(input int nsteps, input logic hreq);
        logic [32:0] cw;
        logic [1:0]  prev;
        fetch($urandom_range(0, 4), $urandom());
        prev = 2'b00;
        for (int k = 0; k < nsteps; k++) begin
            cw = rand_cw();
            if (k == nsteps - 1) begin
                cw[1:0] = 2'b00;
                exec(cw, hreq, prev, k);
            end else begin
                cw[1:0] = 2'($urandom_range(1, 3));
                exec(cw, 1'($urandom_range(0, 1)), prev, k);
            end
            prev = cw[1:0];
        end
    endtask

    task automatic check_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_ready = 1'b1;
            bus.imem_data  = $urandom();
            bus.cw_in      = rand_cw();
            #1;
            chk("halt.cw_out", bus.cw_out, NOP);
            chk("halt.imem_req", 33'(bus.imem_req), 33'd0);
            check_status("halt");
            step_clk();
        end
        bus.imem_ready = 1'b0;
    endtask

    initial begin
        logic [32:0] cw;
        bus.imem_ready = 1'b0;
        bus.imem_data  = 32'h0;
        bus.cw_in      = 33'h0;
        bus.halt_req   = 1'b0;

        // MOVZ single step
        do_reset();
        fetch(0, 32'hD280_0541);
        cw = rand_cw(); cw[1:0] = 2'b00;
        exec(cw, 1'b0, 2'b00, 0);

        // Two-step instruction with PC/status fields suppressed on the first step
        fetch(1, 32'h9100_0421);
        cw = rand_cw(); cw[1:0] = 2'b01; cw[5:4] = 2'b01; cw[2] = 1'b1; cw[6] = 1'b1;
        exec(cw, 1'b0, 2'b00, 0);
        cw = rand_cw(); cw[1:0] = 2'b00; cw[5:4] = 2'b01;
        exec(cw, 1'b0, 2'b01, 1);

        // Random multi-step instructions, including the full MAX_STEPS length
        for (int n = 0; n < 12; n++)
            run_instr($urandom_range(1, MAXSTEPS), 1'b0);
        run_instr(MAXSTEPS, 1'b0);

        // Halt on a final step, then reset restores FETCH with retired cleared
        run_instr(2, 1'b1);
        check_halted(3);
        do_reset();

        // Fetch waiting one cycle short of the timeout still succeeds
        fetch(TIMEOUT - 1, $urandom());
        cw = rand_cw(); cw[1:0] = 2'b00;
        exec(cw, 1'b0, 2'b00, 0);

        // Fetch timeout
        do_reset();
        for (int i = 0; i < TIMEOUT; i++) begin
            bus.imem_ready = 1'b0;
            #1;
            chk("timeout.halted_before", 33'(bus.halted), 33'd0);
            step_clk();
        end
        m_fault = 1'b1; m_halted = 1'b1;
        check_halted(3);

        // Step overrun: next_state stuck at 1 with writes requested
        do_reset();
        fetch(0, $urandom());
        for (int k = 0; k < MAXSTEPS; k++) begin
            cw = rand_cw(); cw[1:0] = 2'b01; cw[9] = 1'b1; cw[7] = 1'b1;
            exec(cw, 1'b0, (k == 0) ? 2'b00 : 2'b01, k);
        end
        check_halted(2);

        // Reset while in the second execute step
        do_reset();
        run_instr(1, 1'b0);
        fetch(0, $urandom());
        cw = rand_cw(); cw[1:0] = 2'b01;
        exec(cw, 1'b0, 2'b00, 0);
        bus.cw_in = rand_cw();
        #1;
        chk("mid_exec.state", 33'(bus.state), 33'd1);
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        m_I = 32'h0; m_retired = 32'h0; m_fault = 1'b0; m_halted = 1'b0;
        #1;
        check_status("mid_exec_reset");
        chk("mid_exec_reset.cw_out", bus.cw_out, NOP);
        chk("mid_exec_reset.imem_req", 33'(bus.imem_req), 33'd1);
        chk("mid_exec_reset.state", 33'(bus.state), 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
